// File: rtl/ct_had_dbg_pkg.sv
// Shared constants for the HAD debug-request path: FSM state encodings and
// debug-cause codes.
package ct_had_dbg_pkg;

    localparam int CAUSE_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_WAIT_ON = 2'b10,
        ST_DBG     = 2'b11
    } dbgreq_state_e;

    localparam logic [CAUSE_W-1:0] CAUSE_NONE    = 3'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_MBKPT   = 3'd1;
    localparam logic [CAUSE_W-1:0] CAUSE_TRACE   = 3'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_HALTREQ = 3'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_STEP    = 3'd4;

endpackage

// File: rtl/ct_had_dbgreq_arb.sv
// Fixed-priority encoder of the four halt sources:
// mbkpt > trace > haltreq > step.
module ct_had_dbgreq_arb
    import ct_had_dbg_pkg::*;
(
    input  logic               i_mbkpt,
    input  logic               i_trace,
    input  logic               i_haltreq,
    input  logic               i_step,
    output logic               o_any_vld,
    output logic [CAUSE_W-1:0] o_cause
);

    assign o_any_vld = i_mbkpt | i_trace | i_haltreq | i_step;

    always_comb begin
        o_cause = CAUSE_NONE;
        if (i_mbkpt) begin
            o_cause = CAUSE_MBKPT;
        end else if (i_trace) begin
            o_cause = CAUSE_TRACE;
        end else if (i_haltreq) begin
            o_cause = CAUSE_HALTREQ;
        end else if (i_step) begin
            o_cause = CAUSE_STEP;
        end
    end

endmodule

// File: rtl/ct_had_dbgreq_ctrl.sv
// HAD debug-request controller: arbitrates halt sources, latches the cause and
// runs the req/ack handshake to RTU. Optional REQ timeout: CT_HAD_DBGREQ_TIMEOUT_EN.
module ct_had_dbgreq_ctrl
    import ct_had_dbg_pkg::*;
`ifdef CT_HAD_DBGREQ_TIMEOUT_EN
#(
    parameter int TO_CYCLES = 255
)
`endif
(
    input  logic               cpuclk,
    input  logic               cpurst_b,
    input  logic               inst_bkpt_dbgreq,
    input  logic               trace_ctrl_req,
    input  logic               ctrl_step_req,
    input  logic               ctrl_haltreq,
    input  logic               rtu_had_dbg_ack,
    input  logic               rtu_yy_xx_dbgon,
    input  logic               ctrl_exit_dbg,
    output logic               had_rtu_dbg_req,
    output logic [CAUSE_W-1:0] dbgreq_cause,
    output logic [1:0]         dbgreq_state,
    output logic               dbgreq_timeout
);

    dbgreq_state_e      r_state;
    dbgreq_state_e      w_state_nxt;
    logic [CAUSE_W-1:0] r_cause;
    logic [CAUSE_W-1:0] w_arb_cause;
    logic               w_any_vld;
    logic               w_req_start;
    logic               w_to_hit;
    logic               w_unused_exit;

    // Resume is handled elsewhere; dbgon falling is what ends debug mode here.
    assign w_unused_exit = ctrl_exit_dbg;

    ct_had_dbgreq_arb u_arb (
        .i_mbkpt   (inst_bkpt_dbgreq),
        .i_trace   (trace_ctrl_req),
        .i_haltreq (ctrl_haltreq),
        .i_step    (ctrl_step_req),
        .o_any_vld (w_any_vld),
        .o_cause   (w_arb_cause)
    );

    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples pre-edge values regardless of block ordering.
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable
        // unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        w_req_start = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (rtu_yy_xx_dbgon) begin
                    w_state_nxt = ST_DBG;
                end else if (w_any_vld) begin
                    w_state_nxt = ST_REQ;
                    w_req_start = 1'b1;
                end
            end
            ST_REQ: begin
                if (rtu_had_dbg_ack) begin
                    w_state_nxt = ST_WAIT_ON;
                end else if (w_to_hit) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_ON: begin
                if (rtu_yy_xx_dbgon) begin
                    w_state_nxt = ST_DBG;
                end
            end
            ST_DBG: begin
                if (!rtu_yy_xx_dbgon) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_cause <= CAUSE_NONE;
        end else if (w_req_start) begin
            r_cause <= w_arb_cause;
        end
    end

`ifdef CT_HAD_DBGREQ_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);

    logic [7:0] r_to_cnt;
    logic       r_timeout;

    // Counter holds the number of REQ cycles already spent; ack wins a tie.
    assign w_to_hit = (r_state == ST_REQ) && !rtu_had_dbg_ack && (r_to_cnt == TO_LAST);

    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_to_cnt  <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            if ((r_state == ST_REQ) && (w_state_nxt == ST_REQ)) begin
                r_to_cnt <= r_to_cnt + 8'd1;
            end else begin
                r_to_cnt <= 8'd0;
            end
            if (w_req_start) begin
                r_timeout <= 1'b0;
            end else if (w_to_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign dbgreq_timeout = r_timeout;
`else
    assign w_to_hit       = 1'b0;
    assign dbgreq_timeout = 1'b0;
`endif

    assign had_rtu_dbg_req = (r_state == ST_REQ);
    assign dbgreq_cause    = r_cause;
    assign dbgreq_state    = r_state;

endmodule

// File: tb/tb_ct_had_dbgreq_ctrl.sv
// Directed self-checking bench for ct_had_dbgreq_ctrl; the timeout scenario
// follows CT_HAD_DBGREQ_TIMEOUT_EN (TO_CYCLES=4 when enabled).
module tb_ct_had_dbgreq_ctrl;

    logic       cpuclk;
    logic       cpurst_b;
    logic       inst_bkpt_dbgreq;
    logic       trace_ctrl_req;
    logic       ctrl_step_req;
    logic       ctrl_haltreq;
    logic       rtu_had_dbg_ack;
    logic       rtu_yy_xx_dbgon;
    logic       ctrl_exit_dbg;
    logic       had_rtu_dbg_req;
    logic [2:0] dbgreq_cause;
    logic [1:0] dbgreq_state;
    logic       dbgreq_timeout;

    int checks = 0;
    int errors = 0;

`ifdef CT_HAD_DBGREQ_TIMEOUT_EN
    ct_had_dbgreq_ctrl #(.TO_CYCLES(4)) u_dut (
`else
    ct_had_dbgreq_ctrl u_dut (
`endif
        .cpuclk           (cpuclk),
        .cpurst_b         (cpurst_b),
        .inst_bkpt_dbgreq (inst_bkpt_dbgreq),
        .trace_ctrl_req   (trace_ctrl_req),
        .ctrl_step_req    (ctrl_step_req),
        .ctrl_haltreq     (ctrl_haltreq),
        .rtu_had_dbg_ack  (rtu_had_dbg_ack),
        .rtu_yy_xx_dbgon  (rtu_yy_xx_dbgon),
        .ctrl_exit_dbg    (ctrl_exit_dbg),
        .had_rtu_dbg_req  (had_rtu_dbg_req),
        .dbgreq_cause     (dbgreq_cause),
        .dbgreq_state     (dbgreq_state),
        .dbgreq_timeout   (dbgreq_timeout)
    );

    initial cpuclk = 1'b0;
    always #5 cpuclk = ~cpuclk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge cpuclk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic exp_req, input logic [1:0] exp_st,
                             input logic [2:0] exp_cause);
        check({tag, ".req"},   {31'd0, had_rtu_dbg_req}, {31'd0, exp_req});
        check({tag, ".state"}, {30'd0, dbgreq_state},    {30'd0, exp_st});
        check({tag, ".cause"}, {29'd0, dbgreq_cause},    {29'd0, exp_cause});
    endtask

    // Pulse the given sources for one cycle, then run a full ack/dbgon handshake.
    task automatic run_entry(input string tag, input logic [3:0] srcs, input logic [2:0] exp_cause);
        {inst_bkpt_dbgreq, trace_ctrl_req, ctrl_haltreq, ctrl_step_req} = srcs;
        step();
        {inst_bkpt_dbgreq, trace_ctrl_req, ctrl_haltreq, ctrl_step_req} = 4'b0000;
        check_out({tag, ".req"}, 1'b1, 2'b01, exp_cause);
        rtu_had_dbg_ack = 1'b1;
        step();
        rtu_had_dbg_ack = 1'b0;
        check_out({tag, ".wait"}, 1'b0, 2'b10, exp_cause);
        rtu_yy_xx_dbgon = 1'b1;
        step();
        check_out({tag, ".dbg"}, 1'b0, 2'b11, exp_cause);
        rtu_yy_xx_dbgon = 1'b0;
        step();
        check_out({tag, ".idle"}, 1'b0, 2'b00, exp_cause);
    endtask

    initial begin
        cpurst_b         = 1'b0;
        inst_bkpt_dbgreq = 1'b0;
        trace_ctrl_req   = 1'b0;
        ctrl_step_req    = 1'b0;
        ctrl_haltreq     = 1'b0;
        rtu_had_dbg_ack  = 1'b0;
        rtu_yy_xx_dbgon  = 1'b0;
        ctrl_exit_dbg    = 1'b0;
        #12;
        check_out("reset", 1'b0, 2'b00, 3'd0);
        check("reset.timeout", {31'd0, dbgreq_timeout}, 32'd0);
        cpurst_b = 1'b1;
        step();
        check_out("idle_quiet", 1'b0, 2'b00, 3'd0);

        // Trace request, ack three cycles after the request rises.
        trace_ctrl_req = 1'b1;
        step();
        trace_ctrl_req = 1'b0;
        check_out("trace.req", 1'b1, 2'b01, 3'd2);
        step();
        step();
        check_out("trace.hold", 1'b1, 2'b01, 3'd2);
        rtu_had_dbg_ack = 1'b1;
        ctrl_exit_dbg   = 1'b1;
        step();
        rtu_had_dbg_ack = 1'b0;
        check_out("trace.ack", 1'b0, 2'b10, 3'd2);
        step();
        ctrl_exit_dbg = 1'b0;
        check_out("trace.exit_ignored", 1'b0, 2'b10, 3'd2);
        rtu_yy_xx_dbgon = 1'b1;
        step();
        check_out("trace.dbg", 1'b0, 2'b11, 3'd2);
        rtu_yy_xx_dbgon = 1'b0;
        step();
        check_out("trace.idle", 1'b0, 2'b00, 3'd2);

        // Priority table.
        run_entry("mb_hr", 4'b1010, 3'd1);
        run_entry("tr_hr_st", 4'b0111, 3'd2);
        run_entry("hr_st", 4'b0011, 3'd3);
        run_entry("st", 4'b0001, 3'd4);
        run_entry("all", 4'b1111, 3'd1);

        // Step arriving during REQ for a haltreq is dropped.
        ctrl_haltreq = 1'b1;
        step();
        ctrl_haltreq  = 1'b0;
        ctrl_step_req = 1'b1;
        check_out("late_step.req", 1'b1, 2'b01, 3'd3);
        step();
        ctrl_step_req = 1'b0;
        check_out("late_step.hold", 1'b1, 2'b01, 3'd3);
        rtu_had_dbg_ack = 1'b1;
        step();
        rtu_had_dbg_ack = 1'b0;
        rtu_yy_xx_dbgon = 1'b1;
        step();
        rtu_yy_xx_dbgon = 1'b0;
        check_out("late_step.dbg", 1'b0, 2'b11, 3'd3);
        step();
        step();
        check_out("late_step.no_rereq", 1'b0, 2'b00, 3'd3);

        // Ack and dbgon together.
        trace_ctrl_req = 1'b1;
        step();
        trace_ctrl_req  = 1'b0;
        rtu_had_dbg_ack = 1'b1;
        rtu_yy_xx_dbgon = 1'b1;
        check_out("ack_on.req", 1'b1, 2'b01, 3'd2);
        step();
        rtu_had_dbg_ack = 1'b0;
        check_out("ack_on.wait", 1'b0, 2'b10, 3'd2);
        step();
        check_out("ack_on.dbg", 1'b0, 2'b11, 3'd2);

        // Source during DBG is ignored.
        inst_bkpt_dbgreq = 1'b1;
        step();
        inst_bkpt_dbgreq = 1'b0;
        rtu_yy_xx_dbgon  = 1'b0;
        check_out("dbg_src_ignored", 1'b0, 2'b11, 3'd2);
        step();
        check_out("ack_on.idle", 1'b0, 2'b00, 3'd2);

        // dbgon entered by another path, with a source high at the same time.
        rtu_yy_xx_dbgon = 1'b1;
        ctrl_haltreq    = 1'b1;
        step();
        ctrl_haltreq = 1'b0;
        check_out("ext_dbg", 1'b0, 2'b11, 3'd2);
        rtu_yy_xx_dbgon = 1'b0;
        step();
        check_out("ext_dbg.idle", 1'b0, 2'b00, 3'd2);

        // Asynchronous reset mid-REQ; a stale ack after release is ignored.
        ctrl_haltreq = 1'b1;
        step();
        ctrl_haltreq = 1'b0;
        check_out("rst_mid.req", 1'b1, 2'b01, 3'd3);
        #2;
        cpurst_b = 1'b0;
        #1;
        check_out("rst_mid.async", 1'b0, 2'b00, 3'd0);
        rtu_had_dbg_ack = 1'b1;
        step();
        cpurst_b = 1'b1;
        step();
        rtu_had_dbg_ack = 1'b0;
        check_out("rst_mid.stale_ack", 1'b0, 2'b00, 3'd0);

        // REQ without ack: timeout when enabled, otherwise waits indefinitely.
        trace_ctrl_req = 1'b1;
        step();
        trace_ctrl_req = 1'b0;
        check_out("to.req", 1'b1, 2'b01, 3'd2);
`ifdef CT_HAD_DBGREQ_TIMEOUT_EN
        step();
        step();
        step();
        check_out("to.last", 1'b1, 2'b01, 3'd2);
        check("to.not_yet", {31'd0, dbgreq_timeout}, 32'd0);
        step();
        check_out("to.expired", 1'b0, 2'b00, 3'd2);
        check("to.flag", {31'd0, dbgreq_timeout}, 32'd1);
        step();
        check("to.sticky", {31'd0, dbgreq_timeout}, 32'd1);
        ctrl_step_req = 1'b1;
        step();
        ctrl_step_req = 1'b0;
        check_out("to.rereq", 1'b1, 2'b01, 3'd4);
        check("to.cleared", {31'd0, dbgreq_timeout}, 32'd0);
`else
        for (int i = 0; i < 10; i++) begin
            step();
        end
        check_out("to.wait", 1'b1, 2'b01, 3'd2);
        check("to.tied", {31'd0, dbgreq_timeout}, 32'd0);
`endif
        rtu_had_dbg_ack = 1'b1;
        step();
        rtu_had_dbg_ack = 1'b0;
        check("to.ack_wait", {30'd0, dbgreq_state}, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
